// File: rtl/rvlab_bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvlab_bram_arb_pkg
// Description : Shared types and helpers for the BRAM arbiter. The struct
//               typedefs describe the default configuration (2 requesters,
//               16-bit word address, 32-bit data). Parameterised instances
//               build identically shaped local types from id_width().
// Revision    : 1.0 - initial release
// ============================================================================
package rvlab_bram_arb_pkg;

    localparam int NumReqDefault    = 2;
    localparam int AddrWidthDefault = 16;
    localparam int DataWidthDefault = 32;

    localparam int IdWidth = $clog2(NumReqDefault);

    // Width of a requester index; never zero, even for degenerate counts.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                        we;
        logic [AddrWidthDefault-1:0] addr;
        logic [DataWidthDefault-1:0] wdata;
        logic [DataWidthDefault-1:0] wmask;
    } bram_req_t;

    typedef struct packed {
        logic               valid;
        logic [IdWidth-1:0] id;
    } rsp_tag_t;

    typedef enum logic [0:0] {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/rvlab_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rvlab_rr_arbiter
// Description : Combinational round-robin search starting at rr_ptr, plus the
//               rr_ptr register. rr_ptr moves to (winner+1) mod NumReq on a
//               grant when advance_en_i is set, otherwise it holds.
// Ports       : clk_i, rst_ni (sync, active-low)
//               req_i[NumReq]        candidate requests
//               advance_en_i         allow rr_ptr to move on a grant
//               gnt_o[NumReq]        one-hot or zero grant
//               gnt_idx_o            index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rvlab_rr_arbiter
    import rvlab_bram_arb_pkg::*;
#(
    parameter int NumReq = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic                          advance_en_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [id_width(NumReq)-1:0]   gnt_idx_o
);

    localparam int IdW = id_width(NumReq);

    logic [IdW-1:0] rr_ptr_q;
    logic [IdW-1:0] rr_ptr_d;
    logic           found;

    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(rr_ptr_q) + k) % NumReq;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IdW'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_en_i && found) begin
            rr_ptr_d = (int'(gnt_idx_o) == NumReq - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvlab_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rvlab_bram_arbiter
// Description : Shares one single-port BRAM among NumReq requesters with
//               round-robin arbitration. The winner is forwarded to the memory
//               in the same cycle; a ReadLatency-deep tag pipeline steers each
//               read response back to its issuer.
// Option      : RVLAB_BRAM_ARB_LOCK_EN - adds a FREE/LOCKED ownership FSM
//               with a MaxLockCycles limit. Undefined: lock_i is ignored.
// Ports       : clk_i, rst_ni (sync, active-low)
//               req_i/lock_i/we_i/addr_i/wdata_i/wmask_i  per-requester access
//               gnt_o, rvalid_o, rdata_o                  per-requester result
//               mem_*_o / mem_rdata_i                     memory port
// Revision    : 1.0 - initial release
// ============================================================================
module rvlab_bram_arbiter
    import rvlab_bram_arb_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 32,
    parameter int ReadLatency   = 1,
    parameter int MaxLockCycles = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_i,
    input  logic [NumReq-1:0]                lock_i,
    input  logic [NumReq-1:0]                we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0] addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumReq-1:0][DataWidth-1:0] wmask_i,
    output logic [NumReq-1:0]                gnt_o,
    output logic [NumReq-1:0]                rvalid_o,
    output logic [DataWidth-1:0]             rdata_o,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [AddrWidth-1:0]             mem_addr_o,
    output logic [DataWidth-1:0]             mem_wdata_o,
    output logic [DataWidth-1:0]             mem_wmask_o,
    input  logic [DataWidth-1:0]             mem_rdata_i
);

    localparam int IdW = id_width(NumReq);

    typedef struct packed {
        logic           valid;
        logic [IdW-1:0] id;
    } tag_t;

    logic [NumReq-1:0] lock_mask;   // requesters eligible this cycle
    logic              advance_en;  // rr_ptr may move this cycle
    logic [NumReq-1:0] arb_req;
    logic [IdW-1:0]    gnt_idx;
    logic              any_gnt;

    // Gating with rst_ni keeps grants and memory strobes quiet during reset.
    assign arb_req = rst_ni ? (req_i & lock_mask) : '0;

    rvlab_rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr_arb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (arb_req),
        .advance_en_i (advance_en),
        .gnt_o        (gnt_o),
        .gnt_idx_o    (gnt_idx)
    );

    assign any_gnt = |gnt_o;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (any_gnt) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_i[gnt_idx];
            mem_addr_o  = addr_i[gnt_idx];
            mem_wdata_o = wdata_i[gnt_idx];
            mem_wmask_o = wmask_i[gnt_idx];
        end
    end

    // ---------------------------------------------------------------- tags
    tag_t tag_q [ReadLatency];
    tag_t tag_d;

    always_comb begin
        tag_d.valid = any_gnt & ~mem_we_o;
        tag_d.id    = gnt_idx;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < ReadLatency; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s < ReadLatency; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // Reads still in flight when reset asserts are suppressed immediately.
    always_comb begin
        rvalid_o = '0;
        if (rst_ni && tag_q[ReadLatency-1].valid) begin
            rvalid_o[tag_q[ReadLatency-1].id] = 1'b1;
        end
    end

    assign rdata_o = (|rvalid_o) ? mem_rdata_i : '0;

`ifdef RVLAB_BRAM_ARB_LOCK_EN
    // ---------------------------------------------------------------- lock
    localparam int CntW = $clog2(MaxLockCycles + 1);

    lock_state_e       state_q, state_d;
    logic [IdW-1:0]    owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              block_q, block_d;  // no re-lock right after a forced release
    logic [NumReq-1:0] owner_mask;

    assign owner_mask = {{(NumReq-1){1'b0}}, 1'b1} << owner_q;
    // rr_ptr already points at owner+1 from the locking grant, so freezing
    // it keeps the post-lock hand-off correct.
    assign lock_mask  = (state_q == ST_LOCKED) ? owner_mask : '1;
    assign advance_en = (state_q == ST_FREE);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        block_d = 1'b0;
        case (state_q)
            ST_FREE: begin
                if (any_gnt && lock_i[gnt_idx] && !block_q) begin
                    if (MaxLockCycles > 1) begin
                        state_d = ST_LOCKED;
                        owner_d = gnt_idx;
                        cnt_d   = CntW'(1);
                    end else begin
                        block_d = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (any_gnt) begin
                    if (!lock_i[owner_q]) begin
                        state_d = ST_FREE;
                    end else if (int'(cnt_q) + 1 >= MaxLockCycles) begin
                        state_d = ST_FREE;
                        block_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!req_i[owner_q] && !lock_i[owner_q]) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_FREE;
            owner_q <= '0;
            cnt_q   <= '0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end
`else
    assign lock_mask  = '1;
    assign advance_en = 1'b1;

    logic unused_lock;
    assign unused_lock = ^lock_i;
    localparam int unused_max_lock = MaxLockCycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvlab_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvlab_bram_arbiter
// Description : Randomised and directed stimulus for rvlab_bram_arbiter with a
//               reference model (round-robin rule, memory array) feeding a
//               response scoreboard checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvlab_bram_arbiter;

    localparam int N   = 2;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req = '0, lock = '0, we = '0;
    logic [N-1:0][AW-1:0] addr = '0;
    logic [N-1:0][DW-1:0] wdata = '0, wmask = '0;
    logic [N-1:0]         gnt, rvalid;
    logic [DW-1:0]        rdata;
    logic                 mem_req, mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata, mem_wmask;
    logic [DW-1:0]        mem_rdata = '0;

    // staged stimulus, applied just after a rising edge by step()
    logic                 rst_v = 1'b0;
    logic [N-1:0]         req_v = '0, lock_v = '0, we_v = '0;
    logic [N-1:0][AW-1:0] addr_v = '0;
    logic [N-1:0][DW-1:0] wdata_v = '0, wmask_v = '0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ref_ptr = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [31:0] bram [int];
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rvlab_bram_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .ReadLatency(LAT), .MaxLockCycles(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt),
        .rvalid_o(rvalid), .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_rdata_i(mem_rdata)
    );

    function automatic logic [31:0] init_val(input int a);
        if (a == 'h10) return 32'hDEADBEEF;
        if (a == 'h42) return 32'hAAAAAAAA;
        return 32'h5A5A0000 ^ (32'(a) * 32'h01010101);
    endfunction

    function automatic logic [31:0] bram_rd(input int a);
        return bram.exists(a) ? bram[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Single-port BRAM, one cycle read latency.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                bram[int'(mem_addr)] = (bram_rd(int'(mem_addr)) & ~mem_wmask) | (mem_wdata & mem_wmask);
            end else begin
                mem_rdata <= bram_rd(int'(mem_addr));
            end
        end
    end

    task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    // Response monitor: exactly one response per due read, silence otherwise.
    always @(negedge clk) begin
        exp_t e;
        logic [127:0] a, x;
        a = {rvalid, rdata};
        x = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            x = {N'(1) << e.id, e.data};
        end
        check(a == x, "read response", a, x);
    end

    // One clock of stimulus; gi returns the requester the model says wins.
    task automatic step(output int gi);
        logic [N-1:0] eg;
        logic [127:0] act, exp;
        int a;
        @(posedge clk); #1;
        rst_n = rst_v; req = req_v; lock = lock_v; we = we_v;
        addr = addr_v; wdata = wdata_v; wmask = wmask_v;
        if (!rst_v) begin
            sb.delete();
            ref_ptr = 0;
        end
        @(negedge clk);
        gi  = -1;
        eg  = '0;
        exp = '0;
        if (rst_v) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ref_ptr + k) % N;
                if (gi < 0 && req_v[i]) gi = i;
            end
        end
        if (gi >= 0) begin
            eg[gi]  = 1'b1;
            exp     = {eg, 1'b1, we_v[gi], addr_v[gi], wdata_v[gi], wmask_v[gi]};
            ref_ptr = (gi + 1) % N;
            a       = int'(addr_v[gi]);
            if (we_v[gi]) ref_mem[a] = (ref_rd(a) & ~wmask_v[gi]) | (wdata_v[gi] & wmask_v[gi]);
            else          sb.push_back('{id: gi, data: ref_rd(a), due: cyc + LAT});
        end
        act = {gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask};
        check(act == exp, "grant/forward", act, exp);
    endtask

    task automatic do_reset();
        int g;
        rst_v = 1'b0;
        repeat (2) step(g);
        rst_v = 1'b1;
    endtask

    initial begin
        int g;
        do_reset();

        // single read from req0
        req_v = 2'b01; we_v = 2'b00; addr_v[0] = 16'h0010;
        step(g);
        req_v = '0;
        step(g);

        // contention, both reading continuously
        do_reset();
        req_v = 2'b11; we_v = 2'b00; addr_v[0] = 16'h0020; addr_v[1] = 16'h0021;
        repeat (6) step(g);
        req_v = '0;
        step(g);

        // masked write then read on req1
        req_v = 2'b10; we_v = 2'b10; addr_v[1] = 16'h0042;
        wdata_v[1] = 32'h12345678; wmask_v[1] = 32'h0000FFFF;
        step(g);
        we_v = 2'b00;
        step(g);
        req_v = '0;
        step(g);

        // reset while a read is in flight; grant requests during reset
        req_v = 2'b01; we_v = 2'b00; addr_v[0] = 16'h0010;
        step(g);
        rst_v = 1'b0; req_v = 2'b11;
        repeat (2) step(g);
        rst_v = 1'b1;
        step(g);
        req_v = '0;
        step(g);

        // withdrawal: req1 asserts for a single cycle behind req0
        do_reset();
        req_v = 2'b11; we_v = 2'b00; addr_v[0] = 16'h0003; addr_v[1] = 16'h0005;
        step(g);
        req_v = 2'b01;
        repeat (3) step(g);
        req_v = '0;
        step(g);

        // randomised traffic; requests are held until the model grants them
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 1) == 1) begin
                    req_v[i]   = 1'b1;
                    we_v[i]    = ($urandom_range(0, 2) == 0);
                    addr_v[i]  = AW'($urandom_range(0, 31));
                    wdata_v[i] = $urandom;
                    wmask_v[i] = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
                end
            end
            step(g);
            if (g >= 0) req_v[g] = 1'b0;
        end
        req_v = '0;
        repeat (3) step(g);
        check(sb.size() == 0, "scoreboard drained", 128'(sb.size()), 128'(0));

`ifdef RVLAB_BRAM_ARB_LOCK_EN
        // req0 holds lock: 16 consecutive grants, then req1 in cycle 17
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            req = 2'b11; lock = 2'b01; we = 2'b11;
            @(negedge clk);
            check(gnt == ((c <= 16) ? 2'b01 : 2'b10), "lock grant", 128'(gnt),
                  128'((c <= 16) ? 2'b01 : 2'b10));
        end
        @(posedge clk); #1;
        req = '0; lock = '0; we = '0;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvlab_bram_arbiter.md
# rvlab_bram_arbiter

Shares one single-port block RAM, with byte-masked SRAM-style access, among `NumReq` requesters such as the TL-UL SRAM adapter and the FIR coefficient and sample DMA engines. Requests are arbitrated round-robin. Each grant is forwarded to the memory in the same cycle. A tag pipeline of depth `ReadLatency` routes each read response back to the requester that issued it.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters, minimum 2.
- `AddrWidth`, default 16: word address width.
- `DataWidth`, default 32: data width; mask is bit-granular, with bytes checked at bits 0/8/16/24.
- `ReadLatency`, default 1: cycles from memory request to `mem_rdata_i` valid.
- `MaxLockCycles`, default 16: maximum consecutive locked grants (lock feature only).

Ports (clock and reset; reset is synchronous and active-low):
- `clk_i`  in  1  clock
- `rst_ni`  in  1  synchronous, active-low reset
- `req_i`  in  NumReq  access request per requester; held until granted
- `lock_i`  in  NumReq  keep ownership after this grant (ignored without the lock feature)
- `we_i`  in  NumReq  write enable
- `addr_i`  in  NumReq×AddrWidth  word address
- `wdata_i`  in  NumReq×DataWidth  write data
- `wmask_i`  in  NumReq×DataWidth  write bit mask
- `gnt_o`  out  NumReq  one-hot or zero; access accepted this cycle
- `rvalid_o`  out  NumReq  read data valid for this requester
- `rdata_o`  out  DataWidth  shared read data
- `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_wmask_o`  out  memory-side access fields
- `mem_rdata_i`  in  DataWidth  memory read data

## Operation
- **Arbitration.** Grant is combinational: `gnt_o[i]` goes to the first requester with `req_i` set, searching from `rr_ptr` upward, modulo `NumReq`.
- **Forwarding.** `mem_req_o = |gnt_o`. The memory fields come from the granted requester. When nothing is granted, all memory fields are 0.
- **Pointer update.** On any grant to `i`, `rr_ptr <= (i+1) mod NumReq`. With no grant, `rr_ptr` holds.
- **Response pipeline.** A `ReadLatency`-deep shift register carries {valid, id} per stage.
  - A stage is pushed with valid=1 only for a granted read (`we`=0). Writes push valid=0 and never produce `rvalid`.
  - `rvalid_o[id]` is asserted when the last stage is valid.
  - `rdata_o = mem_rdata_i` when any `rvalid_o` is set, otherwise 0.
- **Write/read ordering.** Write then read to the same address in back-to-back cycles returns the new data; the memory is write-first.
- **Ownership.** Any number of reads can be in flight, each tracked by its own stage, so ownership switches every cycle without bubbles.
- **Reset.**
  - While `rst_ni` = 0: `gnt_o`, `mem_req_o` and all memory fields are forced to 0.
  - On the reset edge: `rr_ptr` = 0, the pipeline is cleared, `rvalid_o` = 0, `rdata_o` = 0.
  - Reads in flight when reset asserts are dropped and never return.

## Timing
- Grant latency is 0 cycles when uncontested.
- Worst-case wait with N active requesters and no locks is N−1 cycles.
- A read granted in cycle t gets `rvalid_o` in cycle t+`ReadLatency`. The read data occupies the same cycle.
- Simultaneous events: a new grant and a response delivery in the same cycle are independent and both proceed.
- Requester obligations: hold `req_i` and the access fields stable until `gnt_o`. Dropping `req_i` before the grant is allowed and is treated as withdrawal.

## Configuration
- **`RVLAB_BRAM_ARB_LOCK_EN` defined:** two-state FSM, FREE and LOCKED(owner).
  - FREE → LOCKED(i): on a grant to `i` with `lock_i[i]` = 1. The lock counter loads 1.
  - In LOCKED, only the owner is grantable; other requests stall and `rr_ptr` is frozen.
  - LOCKED → FREE on any of:
    - a grant to the owner with `lock_i` = 0;
    - a cycle where the owner has `req_i` = 0 and `lock_i` = 0;
    - the counter reaching `MaxLockCycles` granted cycles. That grant is served, then the state goes FREE, `rr_ptr` becomes owner+1, and the lock is not re-taken in the next cycle.
  - Reset → FREE.
- **Macro not defined:** `lock_i` is ignored, there is no FSM and no counter, and behaviour is pure round-robin.

## Structure
- **Package `rvlab_bram_arb_pkg`:**
  - typedef `bram_req_t` {`we`, `addr`, `wdata`, `wmask`};
  - typedef `rsp_tag_t` {`valid`, `id`};
  - constant `IdWidth` = $clog2(`NumReq`).
- **Sub-module `rvlab_rr_arbiter`:** holds the round-robin search and the `rr_ptr` register, with inputs `req` and `advance_en` and outputs `gnt` and `gnt_idx`. The top level owns the forwarding mux, the tag pipeline and the lock FSM.

## Test plan
1. **Single read.** Req0 reads addr 0x0010 while memory holds 0xDEADBEEF → `gnt_o` = 01 in the same cycle; `rvalid_o` = 01 with `rdata_o` = 0xDEADBEEF one cycle later; `rvalid_o[1]` stays 0.
2. **Contention.** Req0 and req1 both request reads continuously for 6 cycles from reset → grants alternate 0,1,0,1,0,1; each `rvalid` follows its grant by 1 cycle with the correct id.
3. **Write then read.** Req1 writes 0x12345678 with mask 0x0000FFFF over 0xAAAAAAAA at 0x0042, then reads it → no `rvalid` for the write; the read returns 0xAAAA5678.
4. **Reset mid-read.** Req0 read is granted at t; `rst_ni` = 0 at t+1 → `rvalid_o` = 0 at t+1 and after; the next grant after reset goes to req0 (`rr_ptr` = 0).
5. **Lock** (with `RVLAB_BRAM_ARB_LOCK_EN`). Req0 holds `lock` and `req` while req1 requests constantly → req0 gets 16 consecutive grants, then req1 is granted in cycle 17.
6. **Withdrawal.** Req1 asserts `req` for one cycle while req0 has priority, then drops it → req1 is never granted, `mem_req_o` shows only req0 accesses, and no stray `rvalid_o[1]`.
